// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_dbg_pkg
// Description : Shared types and constants for the UART debug command parser.
//               Defines command opcodes, error codes, the ASCII characters
//               that structure a command line, and the parser state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package uart_dbg_pkg;

    typedef enum logic [1:0] {
        OP_HELP  = 2'd0,
        OP_TEST  = 2'd1,
        OP_READ  = 2'd2,
        OP_WRITE = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_OPCODE  = 3'd1,
        ERR_HEX     = 3'd2,
        ERR_COUNT   = 3'd3,
        ERR_OVERRUN = 3'd4,
        ERR_SEP     = 3'd5
    } err_code_t;

    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;
    localparam logic [7:0] c_ASCII_SP    = 8'h20;
    localparam logic [7:0] c_ASCII_QMARK = 8'h3F;  // '?'
    localparam logic [7:0] c_ASCII_T     = 8'h74;  // 't'
    localparam logic [7:0] c_ASCII_R     = 8'h52;  // 'R'
    localparam logic [7:0] c_ASCII_W     = 8'h57;  // 'W'

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EOL     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA    = 3'd3,
        ST_DISCARD = 3'd4,
        ST_ISSUE   = 3'd5
    } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : ascii_hex_decode
// Description : Combinational ASCII hex digit decoder (case-insensitive).
//   i_byte    in  8  ASCII character
//   o_is_hex  out 1  character is 0-9, A-F or a-f
//   o_nibble  out 4  value of the digit (0 when not hex)
// Revision    : 1.0  initial release
// ============================================================================
module ascii_hex_decode (
    input  logic [7:0] i_byte,
    output logic       o_is_hex,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_is_hex = 1'b0;
        o_nibble = 4'd0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0];
        end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                     (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
            // 'A'..'F' and 'a'..'f' share the low nibble 1..6
            o_is_hex = 1'b1;
            o_nibble = i_byte[3:0] + 4'd9;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Parses ASCII debug command lines ("?", "t", "R<addr>",
//               "W<addr> <data>", each CR-terminated) from a UART byte stream
//               into decoded commands on a valid/ready handshake, with a
//               one-cycle error strobe for malformed lines.
//   clk          in   1       system clock
//   rst          in   1       synchronous reset, active-high
//   rx_valid_i   in   1       received byte strobe
//   rx_data_i    in   8       received byte
//   cmd_valid_o  out  1       decoded command available
//   cmd_ready_i  in   1       downstream accepts command
//   cmd_op_o     out  2       0=HELP 1=TEST 2=READ 3=WRITE
//   cmd_addr_o   out  ADDR_W  address
//   cmd_wdata_o  out  DATA_W  write data
//   err_valid_o  out  1       one-cycle error strobe
//   err_code_o   out  3       last error code
//   busy_o       out  1       parser not idle
// Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int ADDR_W = 32,  // multiple of 4, at most 60
    parameter int DATA_W = 32   // multiple of 4, at most 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [1:0]        cmd_op_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [DATA_W-1:0] cmd_wdata_o,
    output logic              err_valid_o,
    output logic [2:0]        err_code_o,
    output logic              busy_o
);

    import uart_dbg_pkg::*;

    localparam logic [3:0] c_ADDR_DIGITS = 4'(ADDR_W / 4);
    localparam logic [3:0] c_DATA_DIGITS = 4'(DATA_W / 4);

    parse_state_t      r_state,       w_state_nxt;
    cmd_op_t           r_op,          w_op_nxt;
    logic [ADDR_W-1:0] r_addr,        w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,       w_wdata_nxt;
    logic [3:0]        r_cnt,         w_cnt_nxt;
    logic              r_err_valid;
    logic [2:0]        r_err_code;
    // Last byte dropped during ISSUE was not CR: the line is still open.
    logic              r_ovr_discard, w_ovr_discard_nxt;

    logic              w_err_fire;
    err_code_t         w_err_code;
    logic              w_is_hex;
    logic [3:0]        w_nibble;
    logic              w_is_cr;
    logic              w_is_sp;
    logic              w_full;

    ascii_hex_decode u_hex (
        .i_byte   (rx_data_i),
        .o_is_hex (w_is_hex),
        .o_nibble (w_nibble)
    );

    assign w_is_cr = (rx_data_i == c_ASCII_CR);
    assign w_is_sp = (rx_data_i == c_ASCII_SP);
    assign w_full  = (r_state == ST_ADDR) ? (r_cnt == c_ADDR_DIGITS)
                                          : (r_cnt == c_DATA_DIGITS);

    always_comb begin
        w_state_nxt       = r_state;
        w_op_nxt          = r_op;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_cnt_nxt         = r_cnt;
        w_err_fire        = 1'b0;
        w_err_code        = ERR_NONE;
        w_ovr_discard_nxt = (r_state == ST_ISSUE) ? r_ovr_discard : 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (rx_valid_i && !w_is_cr && rx_data_i != c_ASCII_LF) begin
                    // Any opcode starts a fresh command with cleared fields
                    w_addr_nxt  = '0;
                    w_wdata_nxt = '0;
                    w_cnt_nxt   = 4'd0;
                    case (rx_data_i)
                        c_ASCII_QMARK: begin w_op_nxt = OP_HELP;  w_state_nxt = ST_EOL;  end
                        c_ASCII_T:     begin w_op_nxt = OP_TEST;  w_state_nxt = ST_EOL;  end
                        c_ASCII_R:     begin w_op_nxt = OP_READ;  w_state_nxt = ST_ADDR; end
                        c_ASCII_W:     begin w_op_nxt = OP_WRITE; w_state_nxt = ST_ADDR; end
                        default: begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_OPCODE;
                            w_state_nxt = ST_DISCARD;
                        end
                    endcase
                end
            end

            ST_EOL: begin
                if (rx_valid_i) begin
                    if (w_is_cr) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_err_fire  = 1'b1;
                        w_err_code  = ERR_SEP;
                        w_state_nxt = ST_DISCARD;
                    end
                end
            end

            ST_ADDR, ST_DATA: begin
                if (rx_valid_i) begin
                    if (w_is_hex) begin
                        if (w_full) begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_COUNT;
                            w_state_nxt = ST_DISCARD;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                            if (r_state == ST_ADDR)
                                w_addr_nxt = {r_addr[ADDR_W-5:0], w_nibble};
                            else
                                w_wdata_nxt = {r_wdata[DATA_W-5:0], w_nibble};
                        end
                    end else if (w_is_cr) begin
                        // A CR that triggers an error has already closed the
                        // line, so return to IDLE rather than DISCARD.
                        if (!w_full || (r_state == ST_ADDR && r_op == OP_WRITE)) begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_COUNT;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_ISSUE;
                        end
                    end else if (w_is_sp) begin
                        if (!w_full) begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_COUNT;
                            w_state_nxt = ST_DISCARD;
                        end else if (r_state == ST_ADDR && r_op == OP_WRITE) begin
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_SEP;
                            w_state_nxt = ST_DISCARD;
                        end
                    end else begin
                        w_err_fire  = 1'b1;
                        w_err_code  = ERR_HEX;
                        w_state_nxt = ST_DISCARD;
                    end
                end
            end

            ST_DISCARD: begin
                if (rx_valid_i && w_is_cr)
                    w_state_nxt = ST_IDLE;
            end

            ST_ISSUE: begin
                if (rx_valid_i) begin
                    w_err_fire        = 1'b1;
                    w_err_code        = ERR_OVERRUN;
                    w_ovr_discard_nxt = !w_is_cr;
                end
                if (cmd_ready_i)
                    w_state_nxt = w_ovr_discard_nxt ? ST_DISCARD : ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_HELP;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= 4'd0;
            r_err_valid   <= 1'b0;
            r_err_code    <= 3'd0;
            r_ovr_discard <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err_valid   <= w_err_fire;
            r_ovr_discard <= w_ovr_discard_nxt;
            if (w_err_fire)
                r_err_code <= w_err_code;
        end
    end

    assign cmd_valid_o = (r_state == ST_ISSUE);
    assign cmd_op_o    = r_op;
    assign cmd_addr_o  = r_addr;
    assign cmd_wdata_o = r_wdata;
    assign err_valid_o = r_err_valid;
    assign err_code_o  = r_err_code;
    assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Self-checking bench for uart_cmd_parser. Expected commands and
//               error codes are queued as lines are sent and compared when the
//               DUT issues a handshake or raises its error strobe.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_parser;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    exp_cmd_t   exp_cmd_q[$];
    logic [2:0] exp_err_q[$];

    always #5 clk = ~clk;

    uart_cmd_parser #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .cmd_op_o    (cmd_op),
        .cmd_addr_o  (cmd_addr),
        .cmd_wdata_o (cmd_wdata),
        .err_valid_o (err_valid),
        .err_code_o  (err_code),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge; inputs change just after rising edges.
    logic        prev_stall = 1'b0;
    logic [1:0]  prev_op;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(cmd_valid), 64'd1);
                chk("stall_op",    64'(cmd_op),    64'(prev_op));
                chk("stall_addr",  64'(cmd_addr),  64'(prev_addr));
                chk("stall_wdata", 64'(cmd_wdata), 64'(prev_wdata));
            end
            if (err_valid) begin
                if (exp_err_q.size() == 0) begin
                    chk("unexpected_err", 64'(err_code), 64'hFF);
                end else begin
                    chk("err_code", 64'(err_code), 64'(exp_err_q.pop_front()));
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("unexpected_cmd", 64'(cmd_op), 64'hFF);
                end else begin
                    exp_cmd_t e;
                    e = exp_cmd_q.pop_front();
                    chk("cmd_op",    64'(cmd_op),    64'(e.op));
                    chk("cmd_addr",  64'(cmd_addr),  64'(e.addr));
                    chk("cmd_wdata", 64'(cmd_wdata), 64'(e.wdata));
                end
            end
            prev_stall <= cmd_valid && !cmd_ready;
            prev_op    <= cmd_op;
            prev_addr  <= cmd_addr;
            prev_wdata <= cmd_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(1);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_byte(8'h0D);
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        exp_cmd_t e;
        e.op = op; e.addr = a; e.wdata = d;
        exp_cmd_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!cmd_valid && k < 50) begin
            tick(1);
            k++;
        end
        if (!cmd_valid) chk(tag, 64'(cmd_valid), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;
        tick(3);

        // Reset state
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_op",    64'(cmd_op),    64'd0);
        chk("rst_addr",  64'(cmd_addr),  64'd0);
        chk("rst_wdata", 64'(cmd_wdata), 64'd0);
        chk("rst_err_v", 64'(err_valid), 64'd0);
        chk("rst_err_c", 64'(err_code),  64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        rst = 1'b0;
        tick(2);

        // HELP, preceded by an ignored LF
        send_byte(8'h0A);
        push_cmd(2'd0, 32'h0, 32'h0);
        send_line("?");
        chk("help_latency", 64'(cmd_valid), 64'd1);
        tick(3);

        // READ with latency check
        push_cmd(2'd2, 32'hAAAAAAAA, 32'h0);
        send_byte("R");
        chk("read_busy", 64'(busy), 64'd1);
        send_str("AAAAAAAA");
        chk("read_pre_cr", 64'(cmd_valid), 64'd0);
        send_byte(8'h0D);
        chk("read_latency", 64'(cmd_valid), 64'd1);
        tick(3);

        // WRITE with a 5-cycle stall
        cmd_ready = 1'b0;
        push_cmd(2'd3, 32'h12345678, 32'h89ABCDEF);
        send_line("W12345678 89abcdef");
        wait_valid("write_timeout");
        tick(5);
        cmd_ready = 1'b1;
        tick(1);
        chk("write_drop", 64'(cmd_valid), 64'd0);
        tick(2);

        // Bad hex then TEST
        exp_err_q.push_back(3'd2);
        send_line("Rxyz");
        push_cmd(2'd1, 32'h0, 32'h0);
        send_line("t");
        tick(3);

        // Malformed lines: none issue a command
        exp_err_q.push_back(3'd3); send_line("R1234");
        exp_err_q.push_back(3'd1); send_line("X");
        exp_err_q.push_back(3'd3); send_line("R123456789");
        exp_err_q.push_back(3'd5); send_line("t5");
        exp_err_q.push_back(3'd5); send_line("R12345678 ");
        exp_err_q.push_back(3'd3); send_line("W12345678");
        tick(3);
        chk("err_code_hold", 64'(err_code), 64'd3);

        // Reset mid-line
        send_str("W1234");
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        push_cmd(2'd1, 32'h0, 32'h0);
        send_line("t");
        tick(3);

        // Overrun with a non-CR byte: command delivered, rest of line discarded
        cmd_ready = 1'b0;
        push_cmd(2'd1, 32'h0, 32'h0);
        send_line("t");
        wait_valid("ovr_timeout");
        exp_err_q.push_back(3'd4);
        send_byte("x");
        chk("ovr_still_valid", 64'(cmd_valid), 64'd1);
        cmd_ready = 1'b1;
        tick(3);
        send_line("?");               // swallowed by DISCARD
        push_cmd(2'd0, 32'h0, 32'h0);
        send_line("?");
        tick(3);

        // Overrun with CR: back to IDLE after handshake
        cmd_ready = 1'b0;
        push_cmd(2'd2, 32'h000000FF, 32'h0);
        send_line("R000000fF");
        wait_valid("ovr_cr_timeout");
        exp_err_q.push_back(3'd4);
        send_byte(8'h0D);
        cmd_ready = 1'b1;
        tick(2);
        push_cmd(2'd1, 32'h0, 32'h0);
        send_line("t");
        tick(3);

        // Handshake and byte in the same cycle counts as overrun
        cmd_ready = 1'b0;
        push_cmd(2'd0, 32'h0, 32'h0);
        send_line("?");
        wait_valid("simul_timeout");
        tick(1);
        exp_err_q.push_back(3'd4);
        cmd_ready = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = "q";
        tick(1);
        rx_valid  = 1'b0;
        tick(2);
        send_line("t");               // swallowed by DISCARD
        push_cmd(2'd1, 32'h0, 32'h0);
        send_line("t");
        tick(10);

        chk("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
        chk("err_q_empty", 64'(exp_err_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
